dz_uart_rx: RTL and testbench

DZ_UART_RX -- requirements
Module: dz_uart_rx

---
 rtl/dz_uart_rx.sv | 143 ++++++++++++++
 tb/tb_dz_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dz_uart_rx.sv
// DZ11-style serial receiver: 16x oversampled start/data/parity/stop framing
// into a single-character holding register with framing and parity flags.
module dz_uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       rxd,
  input  logic [1:0] length,
  input  logic       parEN,
  input  logic       parODD,
  input  logic       rxCLR,
  output logic [7:0] rxDATA,
  output logic       rxFULL,
  output logic       rxFRME,
  output logic       rxPARE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_bitn;
  logic [7:0] r_shift;
  logic [1:0] r_len;
  logic       r_par_en;
  logic       r_par_odd;
  logic       r_pare;
  logic [2:0] w_last_bit;

  logic [7:0] r_rx_data;
  logic       r_rx_full;
  logic       r_rx_frme;
  logic       r_rx_pare;

  // Synchronizer presets to mark so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
  end

  assign w_rxs      = r_sync[SYNC_STAGES-1];
  assign w_last_bit = {1'b0, r_len} + 3'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitn    <= '0;
      r_shift   <= '0;
      r_len     <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_pare    <= 1'b0;
      r_rx_data <= '0;
      r_rx_full <= 1'b0;
      r_rx_frme <= 1'b0;
      r_rx_pare <= 1'b0;
    end else begin
      if (rxCLR) r_rx_full <= 1'b0;

      if (clken) begin
        unique case (r_state)
          S_IDLE: begin
            if (!w_rxs) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end
          end

          S_START: begin
            if (r_cnt == 4'd7) begin
              if (!w_rxs) begin
                r_state   <= S_DATA;
                r_cnt     <= '0;
                r_bitn    <= '0;
                r_shift   <= '0;
                r_pare    <= 1'b0;
                r_len     <= length;
                r_par_en  <= parEN;
                r_par_odd <= parODD;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end

          // Bits land at their own index, so short characters stay right-justified.
          S_DATA: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_shift[r_bitn] <= w_rxs;
              if (r_bitn == w_last_bit) begin
                r_state <= r_par_en ? S_PARITY : S_STOP;
              end else begin
                r_bitn <= r_bitn + 3'd1;
              end
            end
          end

          S_PARITY: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_pare  <= (^r_shift) ^ w_rxs ^ r_par_odd;
              r_state <= S_STOP;
            end
          end

          S_STOP: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_rx_data <= r_shift;
              r_rx_frme <= ~w_rxs;
              r_rx_pare <= r_par_en & r_pare;
              r_rx_full <= 1'b1;
              r_state   <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rxDATA = r_rx_data;
  assign rxFULL = r_rx_full;
  assign rxFRME = r_rx_frme;
  assign rxPARE = r_rx_pare;

endmodule

// File: tb/tb_dz_uart_rx.sv
// Bench for dz_uart_rx: table of serial characters driven bit-by-bit, loads
// captured by a monitor and matched against a queue of expected results.
module tb_dz_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clken = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] length = 2'd3;
  logic       parEN = 1'b0;
  logic       parODD = 1'b0;
  logic       rxCLR;
  logic [7:0] rxDATA;
  logic       rxFULL;
  logic       rxFRME;
  logic       rxPARE;

  logic clr_man = 1'b0;
  logic clr_auto = 1'b0;
  assign rxCLR = clr_man | clr_auto;

  dz_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .clken  (clken),
    .rxd    (rxd),
    .length (length),
    .parEN  (parEN),
    .parODD (parODD),
    .rxCLR  (rxCLR),
    .rxDATA (rxDATA),
    .rxFULL (rxFULL),
    .rxFRME (rxFRME),
    .rxPARE (rxPARE)
  );

  initial forever #5 clk = ~clk;

  logic gate = 1'b0;
  int   div = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (gate) begin
      div   = (div == 2) ? 0 : div + 1;
      clken = (div == 0);
    end else begin
      clken = 1'b1;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Load monitor: a load is rxFULL rising, or the held word changing while full.
  logic        mon_en = 1'b0;
  logic        in_stop = 1'b0;
  logic        auto_clr = 1'b0;
  logic        prev_full = 1'b0;
  logic [9:0]  prev_w = '0;
  logic [9:0]  mon_cur;
  logic [9:0]  ld_w [0:127];
  logic        ld_stop [0:127];
  int unsigned ld_cnt = 0;

  assign mon_cur = {rxDATA, rxFRME, rxPARE};

  always @(negedge clk) begin
    if (mon_en) begin
      if (rxFULL && (!prev_full || mon_cur != prev_w) && ld_cnt < 128) begin
        ld_w[ld_cnt]    <= mon_cur;
        ld_stop[ld_cnt] <= in_stop;
        ld_cnt          <= ld_cnt + 1;
      end
      prev_full <= rxFULL;
      prev_w    <= mon_cur;
      clr_auto  <= auto_clr & rxFULL;
    end
  end

  typedef struct packed {
    logic [1:0] len;
    logic       pen;
    logic       podd;
    logic [7:0] data;
    logic       pbit;
    logic       stopb;
    logic       clr;
    logic [7:0] exp_data;
    logic       exp_frme;
    logic       exp_pare;
  } vec_t;

  vec_t        vecs [0:9];
  logic [9:0]  sb [$];
  int unsigned rd = 0;
  int unsigned brk_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic was;
    for (int g = 0; g < 8; g++) begin
      was = clken;
      @(posedge clk);
      #2;
      if (was) return;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic drain(input bit brk);
    logic [9:0] e;
    while (rd < ld_cnt) begin
      if (brk) begin
        check("break_load", 32'(ld_w[rd]), 32'({8'h00, 1'b1, 1'b0}));
        brk_cnt++;
      end else if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load: got 0x%0h expected no load", ld_w[rd]);
      end else begin
        e = sb.pop_front();
        check("load_word", 32'(ld_w[rd]), 32'(e));
        check("load_in_stop_bit", 32'(ld_stop[rd]), 32'd1);
      end
      rd++;
    end
  endtask

  // abort_bit >= 0: reset the receiver halfway through that data bit.
  task automatic send(input vec_t v, input bit clr_stop, input int abort_bit, input int gap);
    int nb;
    length = v.len;
    parEN  = v.pen;
    parODD = v.podd;
    rxd    = 1'b1;
    ticks(2);
    if (abort_bit < 0) sb.push_back({v.exp_data, v.exp_frme, v.exp_pare});
    rxd = 1'b0;
    ticks(16);
    length = 2'($urandom());
    parEN  = 1'($urandom());
    parODD = 1'($urandom());
    nb = 5 + int'(v.len);
    for (int i = 0; i < nb; i++) begin
      rxd = v.data[i];
      if (i == abort_bit) begin
        ticks(8);
        pulse_rst();
        return;
      end
      ticks(16);
    end
    if (v.pen) begin
      rxd = v.pbit;
      ticks(16);
    end
    in_stop = 1'b1;
    rxd     = v.stopb;
    if (clr_stop) clr_man = 1'b1;
    ticks(16);
    clr_man = 1'b0;
    in_stop = 1'b0;
    rxd     = 1'b1;
    ticks(gap);
  endtask

  initial begin
    vec_t v;
    int unsigned saved;

    //            len  pen   podd  data   pbit  stop  clr   exp    frme  pare
    vecs[0] = '{2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1};
    vecs[2] = '{2'd2, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[3] = '{2'd2, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[4] = '{2'd0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b1, 1'b0};
    vecs[5] = '{2'd3, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0};
    vecs[6] = '{2'd3, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0};
    vecs[7] = '{2'd1, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
    vecs[8] = '{2'd0, 1'b1, 1'b0, 8'hF3, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
    vecs[9] = '{2'd3, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check("reset_outputs", 32'({rxDATA, rxFULL, rxFRME, rxPARE}), 32'd0);
    mon_en = 1'b1;
    ticks(4);

    // Free-running clken, then clken gated to one cycle in three.
    for (int m = 0; m < 2; m++) begin
      gate = (m == 1);
      ticks(2);
      for (int i = 0; i < 10; i++) begin
        v = vecs[i];
        send(v, 1'b0, -1, v.stopb ? 4 : 20);
        drain(1'b0);
        if (v.clr) begin
          check("full_before_clr", 32'(rxFULL), 32'd1);
          check("data_before_clr", 32'(rxDATA), 32'(v.exp_data));
          clr_man = 1'b1;
          @(posedge clk);
          #2;
          clr_man = 1'b0;
          check("full_after_clr", 32'(rxFULL), 32'd0);
          check("held_after_clr", 32'({rxDATA, rxFRME, rxPARE}),
                32'({v.exp_data, v.exp_frme, v.exp_pare}));
        end
      end
    end
    gate = 1'b0;
    ticks(2);

    // Short low glitch on an idle line is a false start.
    saved = ld_cnt;
    rxd = 1'b0;
    ticks(4);
    rxd = 1'b1;
    ticks(48);
    check("glitch_no_load", ld_cnt, saved);
    drain(1'b0);
    v = '{2'd3, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    send(v, 1'b0, -1, 4);
    drain(1'b0);
    clr_man = 1'b1;
    @(posedge clk);
    #2;
    clr_man = 1'b0;

    // rxCLR held across the stop bit, so it coincides with the load.
    v = '{2'd3, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
    send(v, 1'b1, -1, 4);
    drain(1'b0);
    check("data_after_clr_collision", 32'(rxDATA), 32'h5A);

    // Reset after the third data bit aborts the character.
    saved = ld_cnt;
    v = '{2'd3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0};
    send(v, 1'b0, 3, 0);
    check("abort_outputs", 32'({rxDATA, rxFULL, rxFRME, rxPARE}), 32'd0);
    ticks(48);
    check("abort_no_load", ld_cnt, saved);
    drain(1'b0);
    v = '{2'd3, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
    send(v, 1'b0, -1, 4);
    drain(1'b0);
    check("after_abort_full", 32'(rxFULL), 32'd1);

    // Held break with 5-bit characters: repeated all-zero framing-error loads.
    length   = 2'd0;
    parEN    = 1'b0;
    auto_clr = 1'b1;
    ticks(4);
    rxd = 1'b0;
    ticks(400);
    pulse_rst();
    auto_clr = 1'b0;
    ticks(4);
    drain(1'b1);
    check("break_repeats", 32'((brk_cnt >= 2) && (brk_cnt <= 5)), 32'd1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
